// File: rtl/mac_vector_engine.sv
// Host-loadable dot-product engine: w.x over a runtime length, plus bias, optional accumulate-across-runs.
// Build option: define MAC_VECTOR_SATURATE_EN to clamp oRESULT on overflow (default wraps to OUT_W bits).
module mac_vector_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned BIAS_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned OUT_W  = 16,
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LEN_W  = $clog2(DEPTH + 1)
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iWR_EN,
  input  logic              iWR_SEL,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  input  logic [DATA_W-1:0] iWR_DATA,
  input  logic [BIAS_W-1:0] iBIAS,
  input  logic [LEN_W-1:0]  iLEN,
  input  logic              iACC,
  input  logic              iSTART,
  output logic              oBUSY,
  output logic              oDONE,
  output logic [OUT_W-1:0]  oRESULT,
  output logic              oOVF
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_BIAS, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic signed [DATA_W-1:0]  w_q [DEPTH];
  logic signed [DATA_W-1:0]  x_q [DEPTH];
  logic [ADDR_W-1:0]         idx_q, idx_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic signed [BIAS_W-1:0]  bias_q, bias_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   sum_q, sum_d;
  logic signed [OUT_W-1:0]   res_q, res_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      ovf_q, ovf_d;

  logic [LEN_W-1:0]          eff_len_c;
  logic signed [PROD_W-1:0]  prod_c;
  logic [ACC_W-OUT_W:0]      hi_c;
  logic                      ovf_c;
  logic signed [OUT_W-1:0]   res_c;
  logic                      last_c;
  logic                      wr_ok_c;

  assign eff_len_c = (iLEN > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : iLEN;
  assign prod_c    = PROD_W'(w_q[idx_q]) * PROD_W'(x_q[idx_q]);
  assign last_c    = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;
  assign wr_ok_c   = iWR_EN && (state_q == S_IDLE) && (32'(iWR_ADDR) < DEPTH);

  // Sum fits OUT_W exactly when every bit above the OUT_W sign bit matches it.
  assign hi_c  = acc_q[ACC_W-1:OUT_W-1];
  assign ovf_c = ~((&hi_c) | ~(|hi_c));

  always_comb begin
    res_c = acc_q[OUT_W-1:0];
`ifdef MAC_VECTOR_SATURATE_EN
    if (ovf_c) begin
      res_c = acc_q[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    bias_d  = bias_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          len_d   = eff_len_c;
          bias_d  = iBIAS;
          acc_d   = iACC ? sum_q : '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = (eff_len_c == '0) ? S_BIAS : S_RUN;
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        acc_d  = acc_q + ACC_W'(prod_c);
        idx_d  = idx_q + ADDR_W'(1);
        if (last_c) begin
          state_d = S_BIAS;
        end
      end
      S_BIAS: begin
        busy_d  = 1'b1;
        acc_d   = acc_q + ACC_W'(bias_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        res_d   = res_c;
        ovf_d   = ovf_c;
        sum_d   = acc_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      bias_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      w_q     <= '{default: '0};
      x_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      bias_q  <= bias_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (wr_ok_c) begin
        if (iWR_SEL) begin
          x_q[iWR_ADDR] <= iWR_DATA;
        end else begin
          w_q[iWR_ADDR] <= iWR_DATA;
        end
      end
    end
  end

  assign oBUSY   = busy_q;
  assign oDONE   = done_q;
  assign oRESULT = res_q;
  assign oOVF    = ovf_q;

endmodule

// File: tb/tb_mac_vector_engine.sv
// Bench for mac_vector_engine: timeline reference model checked every cycle, directed literal runs, random runs.
module tb_mac_vector_engine;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int BIAS_W = 16;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 16;
  localparam int ADDR_W = 3;
  localparam int LEN_W  = 4;

  logic              iCLK = 1'b0;
  logic              iRST = 1'b1;
  logic              iWR_EN = 1'b0;
  logic              iWR_SEL = 1'b0;
  logic [ADDR_W-1:0] iWR_ADDR = '0;
  logic [DATA_W-1:0] iWR_DATA = '0;
  logic [BIAS_W-1:0] iBIAS = '0;
  logic [LEN_W-1:0]  iLEN = '0;
  logic              iACC = 1'b0;
  logic              iSTART = 1'b0;
  logic              oBUSY, oDONE, oOVF;
  logic [OUT_W-1:0]  oRESULT;

  mac_vector_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BIAS_W(BIAS_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .iCLK(iCLK), .iRST(iRST), .iWR_EN(iWR_EN), .iWR_SEL(iWR_SEL), .iWR_ADDR(iWR_ADDR),
    .iWR_DATA(iWR_DATA), .iBIAS(iBIAS), .iLEN(iLEN), .iACC(iACC), .iSTART(iSTART),
    .oBUSY(oBUSY), .oDONE(oDONE), .oRESULT(oRESULT), .oOVF(oOVF)
  );

  always #5 iCLK = ~iCLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model: a run accepted at cycle t0 with length L is busy for t0..t0+L+2 and completes at t0+L+2.
  int cyc = 0;
  bit active = 0;
  int end_cyc = 0;
  int wm [DEPTH];
  int xm [DEPTH];
  int stored = 0;
  int pend_sum = 0, pend_res = 0, exp_res = 0;
  bit pend_ovf = 0, exp_ovf = 0, exp_busy = 0, exp_done = 0;

  function automatic void finalize(input int sum, output int res, output bit ovf);
    ovf = (sum > 32767) || (sum < -32768);
`ifdef MAC_VECTOR_SATURATE_EN
    res = ovf ? ((sum < 0) ? -32768 : 32767) : sum;
`else
    res = int'(shortint'(sum));
`endif
  endfunction

  always @(posedge iCLK) begin : model
    bit idle;
    int l, s;
    if (iRST) begin
      active = 0; stored = 0; exp_busy = 0; exp_done = 0; exp_res = 0; exp_ovf = 0;
      for (int i = 0; i < DEPTH; i++) begin wm[i] = 0; xm[i] = 0; end
    end else begin
      idle = !active || (cyc >= end_cyc);
      cyc++;
      exp_done = active && (cyc == end_cyc);
      if (exp_done) begin
        exp_res = pend_res; exp_ovf = pend_ovf; stored = pend_sum;
      end
      exp_busy = active && (cyc <= end_cyc);
      if (idle && iWR_EN && int'(iWR_ADDR) < DEPTH) begin
        if (iWR_SEL) xm[iWR_ADDR] = int'($signed(iWR_DATA));
        else         wm[iWR_ADDR] = int'($signed(iWR_DATA));
      end
      if (idle && iSTART) begin
        l = (int'(iLEN) > DEPTH) ? DEPTH : int'(iLEN);
        s = iACC ? stored : 0;
        for (int k = 0; k < l; k++) s += wm[k] * xm[k];
        s += int'($signed(iBIAS));
        pend_sum = s;
        finalize(s, pend_res, pend_ovf);
        active = 1;
        end_cyc = cyc + l + 2;
        exp_busy = 1;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge iCLK) begin
    if (chk_en) begin
      check("busy", oBUSY, exp_busy);
      check("done", oDONE, exp_done);
      check("result", $signed(oRESULT), exp_res);
      check("ovf", oOVF, exp_ovf);
    end
  end

  task automatic wr(input bit sel, input int addr, input int data);
    iWR_EN = 1'b1; iWR_SEL = sel; iWR_ADDR = ADDR_W'(addr); iWR_DATA = DATA_W'(data);
    @(negedge iCLK);
    iWR_EN = 1'b0;
  endtask

  task automatic load(input int w [DEPTH], input int x [DEPTH]);
    for (int i = 0; i < DEPTH; i++) begin
      wr(1'b0, i, w[i]);
      wr(1'b1, i, x[i]);
    end
  endtask

  // Starts a run at the current negedge and returns at the negedge where oDONE is seen.
  task automatic run(input int bias, input int len, input bit acc, input bit inject,
                     output int lat, output int res, output bit ovf);
    int k;
    iBIAS = BIAS_W'(bias); iLEN = LEN_W'(len); iACC = acc; iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    k = 1;
    if (inject) begin
      iSTART = 1'b1; iWR_EN = 1'b1; iWR_SEL = 1'($urandom);
      iWR_ADDR = ADDR_W'($urandom); iWR_DATA = DATA_W'($urandom);
      @(negedge iCLK);
      iSTART = 1'b0; iWR_EN = 1'b0;
      k = 2;
    end
    while (!oDONE && k < 100) begin
      @(negedge iCLK);
      k++;
    end
    if (!oDONE) check("done_timeout", 0, 1);
    lat = k - 1;
    res = int'($signed(oRESULT));
    ovf = oOVF;
  endtask

  int wv [DEPTH], xv [DEPTH], w127 [DEPTH], wneg [DEPTH];
  int lat, res, dones;
  bit ovf;

  initial begin
    wv = '{1, 2, 1, 2, 3, 4, 3, 4};
    xv = '{-1, -2, 1, 2, 4, 3, -4, -3};
    for (int i = 0; i < DEPTH; i++) begin w127[i] = 127; wneg[i] = -128; end

    repeat (2) @(negedge iCLK);
    chk_en = 1;
    check("rst_busy", oBUSY, 0);
    check("rst_done", oDONE, 0);
    check("rst_result", $signed(oRESULT), 0);
    check("rst_ovf", oOVF, 0);
    iRST = 1'b0;
    @(negedge iCLK);

    load(wv, xv);
    run(10, 8, 0, 0, lat, res, ovf);
    check("t1_latency", lat, 10);
    check("t1_result", res, 10);
    check("t1_ovf", ovf, 0);
    run(10, 8, 1, 0, lat, res, ovf);
    check("t2_acc_result", res, 20);
    run(10, 5, 0, 0, lat, res, ovf);
    check("t3_len5_result", res, 22);

    load(w127, w127);
    run(0, 8, 0, 0, lat, res, ovf);
    check("t4_ovf", ovf, 1);
`ifdef MAC_VECTOR_SATURATE_EN
    check("t4_result", res, 32767);
`else
    check("t4_result", res, -2040);
`endif
    load(wneg, w127);
    run(0, 8, 0, 0, lat, res, ovf);
    check("t5_ovf", ovf, 1);
`ifdef MAC_VECTOR_SATURATE_EN
    check("t5_result", res, -32768);
`else
    check("t5_result", res, 1024);
`endif

    run(-7, 0, 0, 0, lat, res, ovf);
    check("t6_len0_latency", lat, 2);
    check("t6_len0_result", res, -7);
    load(wv, xv);
    run(10, 12, 0, 0, lat, res, ovf);
    check("t6_len12_latency", lat, 10);
    check("t6_len12_result", res, 10);

    // Write and start attempts during a run must be ignored.
    iBIAS = 16'd10; iLEN = 4'd8; iACC = 1'b0; iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    repeat (2) @(negedge iCLK);
    iWR_EN = 1'b1; iWR_SEL = 1'b0; iWR_ADDR = '0; iWR_DATA = 8'd50; iSTART = 1'b1;
    @(negedge iCLK);
    iWR_EN = 1'b0; iSTART = 1'b0;
    dones = 0;
    repeat (25) begin
      if (oDONE) begin dones++; res = int'($signed(oRESULT)); end
      @(negedge iCLK);
    end
    check("t7_done_count", dones, 1);
    check("t7_result", res, 10);
    run(10, 8, 0, 0, lat, res, ovf);
    check("t7_buffer_kept", res, 10);

    // Reset during RUN abandons the run and clears the buffers.
    iBIAS = 16'd10; iLEN = 4'd8; iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    repeat (2) @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    check("t8_busy", oBUSY, 0);
    check("t8_done", oDONE, 0);
    check("t8_result", $signed(oRESULT), 0);
    dones = 0;
    repeat (15) begin
      if (oDONE) dones++;
      @(negedge iCLK);
    end
    check("t8_no_done", dones, 0);
    run(5, 8, 1, 0, lat, res, ovf);
    check("t8_cleared", res, 5);

    // Randomized runs, occasionally back-to-back or with mid-run interference.
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 6)) wr(1'($urandom), $urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
      run(int'($urandom_range(0, 65535)), $urandom_range(0, 15), 1'($urandom),
          ($urandom_range(0, 3) == 0), lat, res, ovf);
      repeat ($urandom_range(0, 2)) @(negedge iCLK);
    end
    repeat (5) @(negedge iCLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
